// File: rtl/clock_divider.sv
// Multi-channel clock-enable generator: each lane counts its own programmable
// ratio and emits a one-cycle tick plus a near-50% divided level, all on clk.

module clock_divider_lane #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic             tick,
  output logic             div_clk,
  output logic             pend
);

  logic [WIDTH-1:0] div, nxt, cnt;
  logic [WIDTH-1:0] apply_div, cnt_nx, div_nx;
  logic [WIDTH:0]   hi;
  logic             wrap, dclk_nx;

  always_comb begin
    wrap      = (cnt == div - WIDTH'(1));
    // a load landing on a wrap/sync edge wins over an older pending ratio
    apply_div = ld ? ld_val : (pend ? nxt : div);
    cnt_nx    = wrap ? '0 : cnt + WIDTH'(1);
    div_nx    = wrap ? apply_div : div;
    hi        = ({1'b0, div_nx} + (WIDTH+1)'(1)) >> 1;
    dclk_nx   = ({1'b0, cnt_nx} < hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= WIDTH'(RESET_DIV);
      nxt     <= '0;
      pend    <= 1'b0;
      cnt     <= '0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else if (sync) begin
      div     <= apply_div;
      pend    <= 1'b0;
      cnt     <= '0;
      tick    <= 1'b0;
      div_clk <= 1'b1;
      if (ld) nxt <= ld_val;
    end else begin
      if (ld) nxt <= ld_val;
      if (en) begin
        cnt     <= cnt_nx;
        div     <= div_nx;
        tick    <= wrap;
        div_clk <= dclk_nx;
        pend    <= wrap ? 1'b0 : (pend | ld);
      end else begin
        tick    <= 1'b0;
        pend    <= pend | ld;
      end
    end
  end

endmodule

module clock_divider #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                load,
  input  logic [SELW-1:0]     ch_sel,
  input  logic [WIDTH-1:0]    div_in,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] div_clk,
  output logic [CHANNELS-1:0] pend
);

  logic [WIDTH-1:0] ld_val;

  // ratio 0 is meaningless; treat it as 1
  assign ld_val = (div_in == '0) ? WIDTH'(1) : div_in;

  // out-of-range ch_sel matches no lane, so such loads are dropped
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    clock_divider_lane #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .ld      (load && (ch_sel == SELW'(g))),
      .ld_val  (ld_val),
      .tick    (tick[g]),
      .div_clk (div_clk[g]),
      .pend    (pend[g])
    );
  end

endmodule

// File: tb/tb_clock_divider.sv
// Directed walk through the divider behaviours followed by a random run,
// every cycle compared against an integer model of the channel rules.

module tb_clock_divider;
  localparam int C  = 5;
  localparam int W  = 8;
  localparam int RD = 2;

  logic         clk = 1'b0;
  logic         rst, sync, load;
  logic [C-1:0] en;
  logic [2:0]   ch_sel;
  logic [W-1:0] div_in;
  logic [C-1:0] tick, div_clk, pend;

  int checks = 0;
  int failures = 0;

  int m_div[C], m_nxt[C], m_cnt[C];
  bit m_pend[C], m_tick[C], m_dclk[C];

  clock_divider #(.CHANNELS(C), .WIDTH(W), .RESET_DIV(RD)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
    .ch_sel(ch_sel), .div_in(div_in),
    .tick(tick), .div_clk(div_clk), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel rules applied to the inputs about to be sampled.
  function automatic void model_step();
    for (int i = 0; i < C; i++) begin
      bit ld = load && (int'(ch_sel) == i);
      int v  = (div_in == 0) ? 1 : int'(div_in);
      if (rst) begin
        m_div[i] = RD; m_nxt[i] = 0; m_pend[i] = 0;
        m_cnt[i] = 0; m_tick[i] = 0; m_dclk[i] = 0;
      end else if (sync) begin
        if (ld) m_div[i] = v;
        else if (m_pend[i]) m_div[i] = m_nxt[i];
        if (ld) m_nxt[i] = v;
        m_pend[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_dclk[i] = 1;
      end else if (en[i]) begin
        bit w = (m_cnt[i] == m_div[i] - 1);
        if (w) begin
          m_cnt[i] = 0;
          if (ld) m_div[i] = v;
          else if (m_pend[i]) m_div[i] = m_nxt[i];
          m_pend[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
          if (ld) m_pend[i] = 1;
        end
        if (ld) m_nxt[i] = v;
        m_tick[i] = w;
        m_dclk[i] = (m_cnt[i] < (m_div[i] + 1) / 2);
      end else begin
        m_tick[i] = 0;
        if (ld) begin m_nxt[i] = v; m_pend[i] = 1; end
      end
    end
  endfunction

  task automatic cyc();
    logic [C-1:0] et, ed, ep;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < C; i++) begin
      et[i] = m_tick[i]; ed[i] = m_dclk[i]; ep[i] = m_pend[i];
    end
    chk("model_tick", tick, et);
    chk("model_div_clk", div_clk, ed);
    chk("model_pend", pend, ep);
  endtask

  task automatic step(input bit l, input int sel, input int val, input bit sy, input bit r);
    load = l; ch_sel = 3'(sel); div_in = W'(val); sync = sy; rst = r;
    cyc();
    load = 0; sync = 0; rst = 0;
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick[ch] && n < 40);
  endtask

  initial begin
    int n;
    bit pat [5] = '{1, 1, 1, 0, 0};
    en = '0; load = 0; sync = 0; rst = 1; ch_sel = '0; div_in = '0;

    // reset state
    cyc(); cyc();
    chk("rst_tick", tick, 0);
    chk("rst_div_clk", div_clk, 0);
    chk("rst_pend", pend, 0);
    rst = 0;

    // ratio 2 on every channel: tick and level both on alternate cycles
    en = '1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("r2_tick", tick, (k % 2 == 0) ? 5'h1f : 5'h00);
      chk("r2_div_clk", div_clk, (k % 2 == 0) ? 5'h1f : 5'h00);
      chk("r2_pend", pend, 0);
    end

    // ch1 <- 5 at cnt=0: pending one cycle, then period 5 with 1,1,1,0,0
    step(1, 1, 5, 0, 0);
    chk("ld5_pend", pend, 5'b00010);
    cyc();
    chk("ld5_applied", pend, 0);
    for (int k = 0; k < 10; k++) begin
      chk("r5_div_clk", div_clk[1], pat[k % 5]);
      chk("r5_tick", tick[1], (k % 5 == 0));
      cyc();
    end

    // ch2 <- 0 behaves as ratio 1; stopping freezes the level high
    step(1, 2, 0, 0, 0);
    cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      chk("r1_tick", tick[2], 1);
      chk("r1_div_clk", div_clk[2], 1);
      cyc();
    end
    en[2] = 0;
    cyc();
    chk("stop_tick", tick[2], 0);
    chk("stop_div_clk", div_clk[2], 1);
    cyc(); cyc();
    en[2] = 1;

    // ch0 ratio 4, reloaded twice before the wrap: last value wins
    step(1, 0, 4, 0, 0);
    n = 0;
    while (!(m_div[0] == 4 && m_cnt[0] == 2 && !m_pend[0]) && n < 20) begin
      cyc(); n++;
    end
    chk("ch0_setup_reached", (n < 20), 1);
    step(1, 0, 3, 0, 0);
    step(1, 0, 6, 0, 0);
    chk("double_load_wrap_tick", tick[0], 1);
    chk("double_load_pend", pend[0], 0);
    wait_tick(0, n);
    chk("ratio6_period", n, 6);

    // sync mid-period realigns; next tick a full period later
    n = 0;
    while (m_cnt[0] != 4 && n < 20) begin cyc(); n++; end
    step(0, 0, 0, 1, 0);
    chk("sync_div_clk", div_clk, 5'h1f);
    chk("sync_tick", tick, 0);
    wait_tick(0, n);
    chk("sync_period6", n, 6);

    // sync together with a load: ratio takes effect immediately
    step(1, 3, 7, 1, 0);
    chk("sync_load_pend", pend, 0);
    wait_tick(3, n);
    chk("sync_load_period7", n, 7);

    // ch_sel beyond the channel count does nothing
    step(1, 5, 9, 0, 0);
    chk("oob5_pend", pend, 0);
    step(1, 7, 9, 0, 0);
    chk("oob7_pend", pend, 0);
    for (int k = 0; k < 14; k++) cyc();

    // reset wins over sync and load with a load already pending
    step(1, 1, 3, 0, 0);
    step(1, 0, 9, 1, 1);
    chk("rst2_tick", tick, 0);
    chk("rst2_div_clk", div_clk, 0);
    chk("rst2_pend", pend, 0);
    cyc();
    chk("rst2_r2_a", tick, 0);
    cyc();
    chk("rst2_r2_b", tick, 5'h1f);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      en = C'($urandom);
      if ($urandom_range(3) == 0) en = '1;
      step(($urandom_range(3) == 0), $urandom_range(7),
           ($urandom_range(4) == 0) ? $urandom_range(255) : $urandom_range(9),
           ($urandom_range(39) == 0), ($urandom_range(199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
